// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receive and transmit paths.
//   uart_rx_state_t : receiver FSM states.
//   UART_SAMPLE_*   : tick-counter values at which the three mid-bit samples
//                     are taken (the majority is resolved at UART_SAMPLE_HI).
//   UART_BIT_LAST   : last tick of a bit period at 16x oversampling.
//   majority3()     : 2-of-3 vote used for bit decisions.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } uart_rx_state_t;

  localparam int         UART_DATA_BITS  = 8;
  localparam logic [3:0] UART_SAMPLE_LO  = 4'd7;
  localparam logic [3:0] UART_SAMPLE_MID = 4'd8;
  localparam logic [3:0] UART_SAMPLE_HI  = 4'd9;
  localparam logic [3:0] UART_BIT_LAST   = 4'd15;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with valid/ready style read side.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO).
//   push       : write request; push_data is the word to store.
//   pop        : read request; only honoured while valid is high.
//   head       : oldest stored word (0 while empty).
//   valid      : FIFO not empty.
//   overrun    : one-clk pulse, registered, when a push was dropped because
//                the FIFO was full and no pop freed a slot in that cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the
  // address bits coincide.
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             overrun_reg;

  logic empty;
  logic full;
  logic pop_ok;
  logic push_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      overrun_reg <= push & ~push_ok;
    end
  end

  // Storage is not reset; the head is masked while empty instead.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign head    = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
  assign valid   = ~empty;
  assign overrun = overrun_reg;

endmodule

// File: rtl/uart_rx_fifo_rx.sv
// uart_rx_fifo_rx: UART receive front end with 16x oversampling, 3-sample
// majority voting, framing-error detection and a small receive FIFO.
//   clk       : system clock.
//   rst_n     : asynchronous active-low reset; drops partial byte and FIFO.
//   baud_tick : one-clk pulse at 16x the baud rate; all FSM activity
//               advances only on these cycles.
//   rx        : asynchronous serial input, idles high.
//   rx_data   : FIFO head byte (0 while empty).
//   rx_valid  : FIFO not empty.
//   rx_ready  : consumer accepts the head byte when rx_valid is high.
//   frame_err : one-clk pulse when a stop bit is sampled low.
//   overrun   : one-clk pulse when a received byte is dropped (FIFO full).
//   busy      : receiver FSM is not idle.
module uart_rx_fifo_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  // Only 16x oversampling is supported; this equals UART_BIT_LAST.
  localparam logic [3:0] TCNT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] IDX_LAST  = 3'(UART_DATA_BITS - 1);

  // Input synchronizer; resets to the idle-high line level.
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= '1;
    else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sync_reg[SYNC_STAGES-1];

  // Receiver FSM state
  uart_rx_state_t state_reg, state_next;
  logic [3:0]     tcnt_reg, tcnt_next;
  logic [2:0]     idx_reg, idx_next;
  logic [7:0]     shift_reg, shift_next;
  logic           s7_reg, s7_next;
  logic           s8_reg, s8_next;
  logic           frame_err_reg, frame_err_next;
  logic           push;
  logic           maj;

  // s9 is the live sample, so the vote is only meaningful at tcnt=9.
  assign maj = majority3(s7_reg, s8_reg, rx_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      tcnt_reg      <= '0;
      idx_reg       <= '0;
      shift_reg     <= '0;
      s7_reg        <= 1'b0;
      s8_reg        <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tcnt_reg      <= tcnt_next;
      idx_reg       <= idx_next;
      shift_reg     <= shift_next;
      s7_reg        <= s7_next;
      s8_reg        <= s8_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    tcnt_next      = tcnt_reg;
    idx_next       = idx_reg;
    shift_next     = shift_reg;
    s7_next        = s7_reg;
    s8_next        = s8_reg;
    frame_err_next = 1'b0;
    push           = 1'b0;

    if (baud_tick) begin
      if (tcnt_reg == UART_SAMPLE_LO)  s7_next = rx_s;
      if (tcnt_reg == UART_SAMPLE_MID) s8_next = rx_s;

      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            state_next = START;
            tcnt_next  = '0;
          end
        end

        START: begin
          if (tcnt_reg == UART_SAMPLE_HI && maj) begin
            // Line went back high mid start bit: treat as a glitch.
            state_next = IDLE;
            tcnt_next  = '0;
          end else if (tcnt_reg == TCNT_LAST) begin
            state_next = DATA;
            tcnt_next  = '0;
            idx_next   = '0;
          end else begin
            tcnt_next = tcnt_reg + 4'd1;
          end
        end

        DATA: begin
          if (tcnt_reg == UART_SAMPLE_HI) shift_next[idx_reg] = maj;
          if (tcnt_reg == TCNT_LAST) begin
            tcnt_next = '0;
            if (idx_reg == IDX_LAST) state_next = STOP;
            else                     idx_next   = idx_reg + 3'd1;
          end else begin
            tcnt_next = tcnt_reg + 4'd1;
          end
        end

        STOP: begin
          // Decide at mid stop bit so a back-to-back start edge is not missed.
          if (tcnt_reg == UART_SAMPLE_HI) begin
            tcnt_next = '0;
            if (maj) begin
              push       = 1'b1;
              state_next = IDLE;
            end else begin
              frame_err_next = 1'b1;
              state_next     = BRK;
            end
          end else begin
            tcnt_next = tcnt_reg + 4'd1;
          end
        end

        BRK: begin
          // Hold off until the line is released so a break is one error.
          if (rx_s) state_next = IDLE;
        end

        default: begin
          state_next = IDLE;
          tcnt_next  = '0;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shift_reg),
    .pop       (rx_ready),
    .head      (rx_data),
    .valid     (rx_valid),
    .overrun   (overrun)
  );

  assign frame_err = frame_err_reg;
  assign busy      = (state_reg != IDLE);

endmodule
